// File: rtl/fft_mag_pkg.sv
// rtl/fft_mag_pkg.sv - shared types, constants and result selection for the FFT magnitude scheduler
package fft_mag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int PIPE_DEPTH = 2;
    localparam int BYTE_W     = 8;

    // With MAG_SAT_EN the result clamps to all-ones of out_w bits; otherwise the caller truncates.
    function automatic logic [15:0] mag_select(input logic [15:0] s, input int out_w);
`ifdef MAG_SAT_EN
        if (32'(s) >= (32'd1 << out_w)) begin
            return 16'hFFFF >> (16 - out_w);
        end
`endif
        return s;
    endfunction

endpackage

// File: rtl/fft_mag_sq_unit.sv
// rtl/fft_mag_sq_unit.sv - shared 2-stage squarer/adder/shift datapath with valid and slot sideband
module fft_mag_sq_unit
    import fft_mag_pkg::*;
#(
    parameter int SCALE_SHIFT = 0,
    parameter int SLOT_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [SLOT_W-1:0] issue_slot,
    input  logic [BYTE_W-1:0] issue_real,
    input  logic [BYTE_W-1:0] issue_imag,
    output logic              res_valid,
    output logic [SLOT_W-1:0] res_slot,
    output logic [15:0]       res_val
);

    logic signed [15:0] r_ext, i_ext, rr, ii;
    logic               s1_valid;
    logic [SLOT_W-1:0]  s1_slot;
    logic [14:0]        s1_rr, s1_ii;
    logic [15:0]        sum;
    logic               unused_sign;

    assign r_ext = {{8{issue_real[BYTE_W-1]}}, issue_real};
    assign i_ext = {{8{issue_imag[BYTE_W-1]}}, issue_imag};
    assign rr    = r_ext * r_ext;
    assign ii    = i_ext * i_ext;
    // A square of a signed byte never exceeds 16384, so bit 15 is always zero.
    assign unused_sign = rr[15] ^ ii[15];
    assign sum   = {1'b0, s1_rr} + {1'b0, s1_ii};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_slot   <= '0;
            s1_rr     <= '0;
            s1_ii     <= '0;
            res_valid <= 1'b0;
            res_slot  <= '0;
            res_val   <= '0;
        end else begin
            s1_valid  <= issue_valid;
            s1_slot   <= issue_slot;
            s1_rr     <= rr[14:0];
            s1_ii     <= ii[14:0];
            res_valid <= s1_valid;
            res_slot  <= s1_slot;
            res_val   <= sum >> SCALE_SHIFT;
        end
    end

endmodule

// File: rtl/fft_mag_scheduler.sv
// rtl/fft_mag_scheduler.sv - frame scheduler feeding one shared magnitude datapath; optional MAG_SAT_EN
module fft_mag_scheduler
    import fft_mag_pkg::*;
#(
    parameter int NUM_BINS    = 4,
    parameter int IN_W        = 16,
    parameter int OUT_W       = 8,
    parameter int SCALE_SHIFT = 0,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_BINS*IN_W-1:0] in_real,
    input  logic [NUM_BINS*IN_W-1:0] in_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_BINS*OUT_W-1:0] out_mag,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
`ifdef MAG_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    state_t                     state, next_state;
    logic [IDX_W-1:0]           idx;
    logic [NUM_BINS*BYTE_W-1:0] cap_real, cap_imag;
    logic                       accept, out_fire;
    logic                       res_valid;
    logic [IDX_W-1:0]           res_slot;
    logic [15:0]                res_val, sel_val;
    logic                       unused_bits;

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign sel_val  = mag_select(res_val, OUT_W);
    // Only the top byte of each sample and the low OUT_W bits of the selection are consumed.
    assign unused_bits = ^{in_real, in_imag, sel_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) next_state = ISSUE;
            end
            ISSUE: if (idx == LAST_IDX) next_state = DRAIN;
            DRAIN: if (res_valid && res_slot == LAST_IDX) next_state = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            cap_real <= '0;
            cap_imag <= '0;
        end else if (accept) begin
            idx <= '0;
            for (int k = 0; k < NUM_BINS; k++) begin
                cap_real[k*BYTE_W +: BYTE_W] <= in_real[k*IN_W + IN_W - BYTE_W +: BYTE_W];
                cap_imag[k*BYTE_W +: BYTE_W] <= in_imag[k*IN_W + IN_W - BYTE_W +: BYTE_W];
            end
        end else if (state == ISSUE) begin
            idx <= idx + IDX_W'(1);
        end
    end

    fft_mag_sq_unit #(
        .SCALE_SHIFT(SCALE_SHIFT),
        .SLOT_W     (IDX_W)
    ) u_sq (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(state == ISSUE),
        .issue_slot (idx),
        .issue_real (cap_real[idx*BYTE_W +: BYTE_W]),
        .issue_imag (cap_imag[idx*BYTE_W +: BYTE_W]),
        .res_valid  (res_valid),
        .res_slot   (res_slot),
        .res_val    (res_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mag   <= '0;
            frame_cnt <= '0;
        end else begin
            if (res_valid) out_mag[res_slot*OUT_W +: OUT_W] <= sel_val[OUT_W-1:0];
            if (out_fire)  frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

`ifdef MAG_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                sat_flag <= 1'b0;
        else if (accept)                                           sat_flag <= 1'b0;
        else if (res_valid && (32'(res_val) >= (32'd1 << OUT_W)))  sat_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_mag_scheduler.sv
// tb/tb_fft_mag_scheduler.sv - self-checking bench for fft_mag_scheduler (shift 0 and shift 7 instances)
module tb_fft_mag_scheduler;

    localparam int NB = 4;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NB*IW-1:0]  in_real = '0;
    logic [NB*IW-1:0]  in_imag = '0;
    logic              in_ready_a, out_valid_a, busy_a;
    logic              in_ready_b, out_valid_b, busy_b;
    logic [NB*OW-1:0]  mag_a, mag_b;
    logic [CW-1:0]     cnt_a, cnt_b;
`ifdef MAG_SAT_EN
    logic              sat_a, sat_b;
`endif

    fft_mag_scheduler #(.NUM_BINS(NB), .IN_W(IW), .OUT_W(OW), .SCALE_SHIFT(0), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_mag(mag_a), .busy(busy_a), .frame_cnt(cnt_a)
`ifdef MAG_SAT_EN
        , .sat_flag(sat_a)
`endif
    );

    fft_mag_scheduler #(.NUM_BINS(NB), .IN_W(IW), .OUT_W(OW), .SCALE_SHIFT(7), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_mag(mag_b), .busy(busy_b), .frame_cnt(cnt_b)
`ifdef MAG_SAT_EN
        , .sat_flag(sat_b)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: square the signed top byte of each sample, sum, shift, then clamp or wrap to 8 bits.
    function automatic logic [31:0] model_mag(input logic [63:0] re, input logic [63:0] im,
                                              input int sh, output logic sat);
        logic [31:0]       m;
        logic signed [7:0] rb, ib;
        int                s;
        m   = '0;
        sat = 1'b0;
        for (int b = 0; b < NB; b++) begin
            rb = re[b*IW + 8 +: 8];
            ib = im[b*IW + 8 +: 8];
            s  = (int'(rb) * int'(rb) + int'(ib) * int'(ib)) >> sh;
            if (s >= 256) begin
                sat = 1'b1;
`ifdef MAG_SAT_EN
                s = 255;
`endif
            end
            m[b*OW +: OW] = s[7:0];
        end
        return m;
    endfunction

    typedef struct {
        logic [63:0] re;
        logic [63:0] im;
        logic [31:0] m0;
        logic [31:0] m7;
        logic        s0;
        logic        s7;
        int          hold;
    } vec_t;

    vec_t vt[4];

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready_a, 1);
        chk({tag, "_out_valid"}, out_valid_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_out_mag"}, mag_a, 0);
        chk({tag, "_out_mag_b"}, mag_b, 0);
        chk({tag, "_frame_cnt"}, cnt_a, 0);
`ifdef MAG_SAT_EN
        chk({tag, "_sat_flag"}, sat_a, 0);
`endif
    endtask

    task automatic run_frame(input logic [63:0] re, input logic [63:0] im,
                             input logic [31:0] e0, input logic [31:0] e7,
                             input logic es0, input logic es7, input int hold);
        int n;
        int lat;
        @(negedge clk);
        in_real   = re;
        in_imag   = im;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 50, 1);
        @(posedge clk);
        #1;
        in_real = {$urandom, $urandom};
        in_imag = {$urandom, $urandom};
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            chk("busy_not_idle", busy_a, !in_ready_a);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, NB + 2);
        chk("out_mag", mag_a, e0);
        chk("out_mag_shift7", mag_b, e7);
        chk("out_valid_shift7", out_valid_b, 1);
        chk("in_ready_in_hold", in_ready_a, 0);
`ifdef MAG_SAT_EN
        chk("sat_flag", sat_a, es0);
        chk("sat_flag_shift7", sat_b, es7);
`else
        if (es0 === 1'bx || es7 === 1'bx) chk("sat_model", 1, 0);
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid_a, 1);
            chk("bp_out_mag", mag_a, e0);
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_frame_cnt", cnt_a, exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        chk("after_out_valid", out_valid_a, 0);
        chk("after_in_ready", in_ready_a, 1);
        chk("frame_cnt", cnt_a, exp_cnt);
        chk("frame_cnt_shift7", cnt_b, exp_cnt);
        @(posedge clk);
        #1;
        chk("single_handshake", cnt_a, exp_cnt);
        chk("idle_busy", busy_a, 0);
    endtask

    initial begin
        logic [63:0] re, im;
        logic [31:0] e0, e7;
        logic        es0, es7;

        vt[0] = '{64'h0500_0000_FD00_0300, 64'h0C00_0000_0000_0400,
                  32'hA900_0919, 32'h0100_0000, 1'b0, 1'b0, 10};
`ifdef MAG_SAT_EN
        vt[1] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_0100,
                  32'h0000_00FF, 32'h0000_0002, 1'b1, 1'b0, 0};
        vt[2] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000,
                  32'h0000_00FF, 32'h0000_00FF, 1'b1, 1'b1, 0};
        vt[3] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 2};
`else
        vt[1] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_0100,
                  32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 0};
        vt[2] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000,
                  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 0};
        vt[3] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000,
                  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 2};
`endif

        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[v]) run_frame(vt[v].re, vt[v].im, vt[v].m0, vt[v].m7, vt[v].s0, vt[v].s7, vt[v].hold);

        // Asynchronous reset two cycles into ISSUE must discard the partial frame.
        @(negedge clk);
        in_real  = vt[3].re;
        in_imag  = vt[3].im;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_accepted", busy_a, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        run_frame(vt[0].re, vt[0].im, vt[0].m0, vt[0].m7, vt[0].s0, vt[0].s7, 0);

        for (int f = 0; f < 255; f++) begin
            re = {$urandom, $urandom};
            im = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) re = re & 64'h0FFF_0FFF_0FFF_0FFF;
            e0 = model_mag(re, im, 0, es0);
            e7 = model_mag(re, im, 7, es7);
            run_frame(re, im, e0, e7, es0, es7, int'($urandom_range(0, 2)));
        end
        chk("frame_cnt_wrap", cnt_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_mag_scheduler.md
Name: fft_mag_scheduler

Overview:
- Time-multiplexes one shared squared-magnitude datapath across the NUM_BINS complex FFT outputs of a frame, instead of one datapath per bin.
- Accepts a full frame with a valid/ready handshake and issues one bin per cycle into a 2-stage pipelined squarer/adder.
- Collects the per-bin magnitudes into an output frame register and presents it with a valid/ready handshake.
- Sits between the FFT butterfly output stage and downstream spectrum consumers.

Parameters:
- NUM_BINS, 4, bins per frame (power of two, 2..16).
- IN_W, 16, width of each real/imag input sample; the top 8 bits feed the datapath.
- OUT_W, 8, width of each magnitude result.
- SCALE_SHIFT, 0, right shift applied to the sum of squares before OUT_W selection (0..9).
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- in_real  in  NUM_BINS*IN_W  bin k real part at [k*IN_W +: IN_W].
- in_imag  in  NUM_BINS*IN_W  bin k imaginary part, same packing.
- out_valid  out  1  magnitude frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_mag  out  NUM_BINS*OUT_W  bin k magnitude at [k*OUT_W +: OUT_W].
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  CNT_W  count of frames completed (output handshakes); wraps.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - out_mag=0, frame_cnt=0.
  - state=IDLE, bin index=0.
  - pipeline valid bits=0.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at edge T, register all in_real/in_imag, set idx=0, go to ISSUE.
- ISSUE:
  - Each cycle, present bin idx to stage 1 and increment idx.
  - After bin NUM_BINS-1 is issued (edge T+NUM_BINS), go to DRAIN.
- Stage 1 (registered):
  - r = signed top byte of real, i = signed top byte of imag (two's complement).
  - Register r*r and i*i as 15-bit unsigned values (max 16384).
- Stage 2 (registered):
  - sum = r2+i2, 16 bits unsigned (max 32768).
  - s = sum >> SCALE_SHIFT.
  - Write the result into out_mag slot k, where k travels with the pipeline.
- DRAIN:
  - Wait for the last slot write (edge T+NUM_BINS+2).
  - On that same edge set out_valid=1 and go to HOLD.
  - out_valid is first high NUM_BINS+2 cycles after the accept edge (6 for the defaults).
- HOLD:
  - out_valid=1; out_mag stable.
  - On out_valid&&out_ready: out_valid=0, frame_cnt+=1 (wraps at 2^CNT_W), go to IDLE.
  - in_ready returns the cycle after the output handshake; there is no same-cycle pass-through.
- in_ready=0 in ISSUE, DRAIN and HOLD. in_valid is ignored there, and input data is don't-care after acceptance.
- Backpressure: out_ready low holds HOLD indefinitely. out_mag must not change.
- out_mag is only updated by stage-2 writes. Slots from the previous frame remain visible while the next frame fills, but out_valid is low then.
- Reset mid-operation: all pipeline contents are discarded and every register returns to its reset value. No partial frame is ever presented.
- The internal input capture register is only loaded on the input handshake.

Optional Feature:
- Macro: MAG_SAT_EN.
- Defined: a slot gets 2^OUT_W-1 when s >= 2^OUT_W, else s[OUT_W-1:0]. An additional output sat_flag is present: the OR of per-bin saturation for the frame, valid with out_valid, cleared on the input handshake.
- Undefined: a slot gets s[OUT_W-1:0] (truncation, wrap). The sat_flag port is absent.

Decomposition:
- Package fft_mag_pkg:
  - state enum (IDLE, ISSUE, DRAIN, HOLD).
  - PIPE_DEPTH=2 constant.
  - BYTE_W=8 constant.
  - function for saturate/truncate selection.
- Sub-module fft_mag_sq_unit:
  - The shared 2-stage squarer/adder/shift datapath.
  - Carries valid and slot-index sideband through the pipeline.
  - Is instantiated once.
- The controller FSM, index counter, frame register and frame_cnt live in fft_mag_scheduler.

Test Plan:
- Basic frame, defaults, out_ready=1:
  - Stimulus: bin0 real=0x0300 imag=0x0400; bin1 real=0xFD00 imag=0; bin2=0,0; bin3 real=0x0500 imag=0x0C00.
  - Required: out_mag bins = 0x19, 0x09, 0x00, 0xA9.
  - Required: out_valid rises 6 cycles after the accept edge; frame_cnt goes 0->1.
- Overflow, bin0 real=0x1000 imag=0x0100 (sum=257):
  - MAG_SAT_EN defined: slot=0xFF and sat_flag=1.
  - MAG_SAT_EN undefined: slot=0x01.
- SCALE_SHIFT=7, bin0 real=0x8000 imag=0x8000 (sum=32768):
  - Required: s=256, so the slot is 0xFF with MAG_SAT_EN and 0x00 without it.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 throughout.
  - Required: out_valid stays 1, out_mag is unchanged, in_ready=0, and no second frame is accepted.
  - Required: after out_ready=1, exactly one handshake occurs, and in_ready=1 on the following cycle.
- Reset mid-ISSUE:
  - Stimulus: assert rst_n=0 asynchronously two cycles after acceptance.
  - Required: all outputs are at reset values immediately.
  - Required: a subsequent frame produces correct results with no stale slots.
- Counter wrap:
  - Stimulus: complete 256 back-to-back frames with CNT_W=8.
  - Required: frame_cnt reads 0 after frame 256, and busy is low only in IDLE.
